// File: rtl/op_tx_pkg.sv
// Shared types and constants for the result-bus UART transmitter.
package op_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam logic TX_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each period.
module uart_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CntW'(CLKS_PER_BIT - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/op_result_uart_tx.sv
// Captures one selector result word on a start/ready handshake and sends it as a UART frame:
// start bit, LSB-first data, optional even parity, stop bit.
module op_result_uart_tx
  import op_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned PARITY_EN    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  output logic              ready,
  output logic              busy,
  output logic              tx,
  output logic              done
);

  localparam int unsigned IdxW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  tx_state_t         state_q, state_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              par_q, par_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              tick;
  logic              timer_clr;

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk (clk),
    .rst (rst),
    .clr (timer_clr),
    .tick(tick)
  );

  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    idx_d     = idx_q;
    par_d     = par_q;
    tx_d      = tx_q;
    done_d    = 1'b0;
    timer_clr = 1'b0;

    if (!ena) begin
      // Dropping ena abandons any frame without a done pulse.
      state_d = IDLE;
      tx_d    = TX_IDLE_LEVEL;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d = START;
            sh_d    = data_in;
            par_d   = ^data_in;
            tx_d    = 1'b0;
          end
        end
        START: begin
          if (tick) begin
            state_d = DATA;
            tx_d    = sh_q[0];
          end
        end
        DATA: begin
          if (tick) begin
            if (idx_q == IdxW'(DATA_W - 1)) begin
              if (PARITY_EN != 0) begin
                state_d = PARITY;
                tx_d    = par_q;
              end else begin
                state_d = STOP;
                tx_d    = TX_IDLE_LEVEL;
              end
            end else begin
              idx_d = idx_q + 1'b1;
              sh_d  = sh_q >> 1;
              tx_d  = sh_d[0];
            end
          end
        end
        PARITY: begin
          if (tick) begin
            state_d = STOP;
            tx_d    = TX_IDLE_LEVEL;
          end
        end
        STOP: begin
          if (tick) begin
            state_d = IDLE;
            tx_d    = TX_IDLE_LEVEL;
            done_d  = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          tx_d    = TX_IDLE_LEVEL;
        end
      endcase
    end

    // Timer and bit index restart on every state change; the timer is parked while idle.
    if (state_d != state_q) begin
      idx_d     = '0;
      timer_clr = 1'b1;
    end
    if (state_q == IDLE) begin
      timer_clr = 1'b1;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      idx_q   <= '0;
      par_q   <= 1'b0;
      tx_q    <= TX_IDLE_LEVEL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      idx_q   <= idx_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign ready = (state_q == IDLE);
  assign busy  = busy_q;
  assign tx    = tx_q;
  assign done  = done_q;

endmodule
